memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access_pkg.sv | 51 +++++
 rtl/memory_access_load_align.sv | 38 +++
 rtl/memory_access.sv | 153 +++++++++++++++
 tb/tb_memory_access.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// Shared types and helpers for the memory-access stage.
// Holds the access-size enum, the FSM state enum and the small
// lane-placement helpers shared by the top level and the load aligner.
package memory_access_pkg;

  typedef enum logic [1:0] {
    DATA_BYTE = 2'd0,
    DATA_HALF = 2'd1,
    DATA_WORD = 2'd2
  } data_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Half accesses must sit on an even byte, words on a 4-byte boundary.
  function automatic logic is_misaligned(input data_size_e size, input logic [1:0] off);
    logic mis;
    case (size)
      DATA_HALF: mis = off[0];
      DATA_WORD: mis = (off != 2'b00);
      default:   mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] lane_enables(input data_size_e size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      DATA_BYTE: be = 4'b0001 << off;
      DATA_HALF: be = 4'b0011 << off;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data is replicated across lanes so the enabled lane always
  // carries the right bytes regardless of the address offset.
  function automatic logic [31:0] lane_wdata(input data_size_e size, input logic [31:0] data);
    logic [31:0] w;
    case (size)
      DATA_BYTE: w = {4{data[7:0]}};
      DATA_HALF: w = {2{data[15:0]}};
      default:   w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// load_align: picks the addressed lane out of a read word and extends it.
// Ports:
//   rdata_i    - raw 32-bit word returned by data memory
//   offset_i   - byte offset of the access within the word
//   size_i     - access size
//   unsigned_i - 1 = zero-extend, 0 = sign-extend
//   data_o     - extended load value
import memory_access_pkg::*;

module load_align (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  data_size_e  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[7:0];
    case (offset_i)
      2'd0: byte_v = rdata_i[7:0];
      2'd1: byte_v = rdata_i[15:8];
      2'd2: byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    half_v = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      DATA_BYTE: data_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
      DATA_HALF: data_o = {{16{~unsigned_i & half_v[15]}}, half_v};
      default:   data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// memory_access: memory stage of a simple pipeline.
// Issues one data-memory access at a time, aligns/extends load data and
// drives the writeback register pair; non-memory results pass straight
// through with one cycle of latency.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   sel_rd_i, mem_re_i, mem_we_i, mem_size_i, load_unsigned_i,
//   alu_result_i, rs2_i         - instruction from the execute stage
//   dmem_req_o/we_o/addr_o/be_o/wdata_o, dmem_gnt_i,
//   dmem_rvalid_i, dmem_rdata_i - data-memory port
//   sel_rd_o, wb_data_o         - registered writeback
//   misaligned_o                - one-cycle pulse on a misaligned access
//   stall_o                     - holds upstream stages
//   state_o                     - current FSM state (debug)
//
// Handshake: a request is presented by dmem_req_o with all request fields
// stable; it is accepted in the cycle dmem_gnt_i is high while dmem_req_o
// is high. For reads, one later cycle with dmem_rvalid_i high returns
// dmem_rdata_i; rvalid outside the WAIT state carries no meaning.
import memory_access_pkg::*;

module memory_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  sel_rd_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  data_size_e  mem_size_i,
  input  logic        load_unsigned_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rs2_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [4:0]  sel_rd_o,
  output logic [31:0] wb_data_o,
  output logic        misaligned_o,
  output logic        stall_o,
  output state_e      state_o
);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        we_q;
  data_size_e  size_q;
  logic        unsigned_q;
  logic [4:0]  rd_q;
  logic [4:0]  sel_rd_q;
  logic [31:0] wb_data_q;
  logic        misaligned_q;

  logic        mem_access;
  logic        misalign;
  logic        aligned_access;
  logic [31:0] load_data;

  always_comb begin
    mem_access     = mem_re_i | mem_we_i;
    misalign       = mem_access & is_misaligned(mem_size_i, alu_result_i[1:0]);
    aligned_access = mem_access & ~misalign;
  end

  load_align u_load_align (
    .rdata_i    (dmem_rdata_i),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .data_o     (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      size_q       <= DATA_BYTE;
      unsigned_q   <= 1'b0;
      rd_q         <= '0;
      sel_rd_q     <= '0;
      wb_data_q    <= '0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (aligned_access) begin
            addr_q     <= alu_result_i;
            be_q       <= lane_enables(mem_size_i, alu_result_i[1:0]);
            wdata_q    <= lane_wdata(mem_size_i, rs2_i);
            we_q       <= mem_we_i;
            size_q     <= mem_size_i;
            unsigned_q <= load_unsigned_i;
            rd_q       <= sel_rd_i;
            sel_rd_q   <= '0;
            state_q    <= REQ;
          end else if (misalign) begin
            misaligned_q <= 1'b1;
            sel_rd_q     <= '0;
          end else begin
            wb_data_q <= alu_result_i;
            sel_rd_q  <= sel_rd_i;
          end
        end
        REQ: begin
          // Either a bubble (still stalled) or store completion: rd is 0 both ways.
          sel_rd_q <= '0;
          if (dmem_gnt_i) state_q <= we_q ? IDLE : WAIT;
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            wb_data_q <= load_data;
            sel_rd_q  <= rd_q;
            state_q   <= IDLE;
          end else begin
            sel_rd_q <= '0;
          end
        end
        default: begin
          sel_rd_q <= '0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  // rst gates stall so upstream is released the instant reset rises,
  // even while an aligned access sits on the inputs.
  always_comb begin
    stall_o = ~rst & (((state_q == IDLE) & aligned_access) |
                      ((state_q == REQ)  & ~(dmem_gnt_i & we_q)) |
                      ((state_q == WAIT) & ~dmem_rvalid_i));
  end

  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = {addr_q[31:2], 2'b00};
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign sel_rd_o     = sel_rd_q;
  assign wb_data_o    = wb_data_q;
  assign misaligned_o = misaligned_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;
  import memory_access_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  sel_rd_i;
  logic        mem_re_i, mem_we_i;
  data_size_e  mem_size_i;
  logic        load_unsigned_i;
  logic [31:0] alu_result_i, rs2_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [4:0]  sel_rd_o;
  logic [31:0] wb_data_o;
  logic        misaligned_o, stall_o;
  state_e      state_o;

  always #5 clk = ~clk;

  memory_access dut (
    .clk(clk), .rst(rst),
    .sel_rd_i(sel_rd_i), .mem_re_i(mem_re_i), .mem_we_i(mem_we_i),
    .mem_size_i(mem_size_i), .load_unsigned_i(load_unsigned_i),
    .alu_result_i(alu_result_i), .rs2_i(rs2_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .sel_rd_o(sel_rd_o), .wb_data_o(wb_data_o), .misaligned_o(misaligned_o),
    .stall_o(stall_o), .state_o(state_o)
  );

  // ---------------- scoreboard ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [68:0] req_q[$];  // {we, addr, be, wdata} at grant
  logic [36:0] wb_q[$];   // {rd, data} at writeback

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compares every granted request and every writeback.
  always @(negedge clk) begin
    if (!rst) begin
      if (dmem_req_o && dmem_gnt_i) begin
        if (req_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_req: got %0h with no expected entry",
                   {dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o});
        end else begin
          check("dmem_req", {dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o}, req_q.pop_front());
        end
      end
      if (sel_rd_o != 5'd0) begin
        if (wb_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_wb: got rd=%0d data=%0h with no expected entry",
                   sel_rd_o, wb_data_o);
        end else begin
          check("writeback", 69'({sel_rd_o, wb_data_o}), 69'(wb_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    sel_rd_i = '0; mem_re_i = 1'b0; mem_we_i = 1'b0; mem_size_i = DATA_BYTE;
    load_unsigned_i = 1'b0; alu_result_i = '0; rs2_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issues one aligned load/store; the bench plays the memory with the
  // given grant and read-data delays. Called at posedge+1.
  task automatic mem_op(input string name, input logic we, input data_size_e size,
                        input logic uns, input logic [31:0] a, input logic [31:0] rs2,
                        input logic [4:0] rd, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_wb, input int exp_lat, input int exp_stalls);
    int  n, req_seen, rv_at, stalls;
    bit  done;
    n = 0; req_seen = 0; rv_at = -1; stalls = 0; done = 1'b0;
    req_q.push_back({we, exp_addr, exp_be, exp_wdata});
    if (!we) wb_q.push_back({rd, exp_wb});
    mem_re_i = ~we; mem_we_i = we; mem_size_i = size; load_unsigned_i = uns;
    alu_result_i = a; rs2_i = rs2; sel_rd_i = rd; dmem_rdata_i = rdata;
    while (!done && n < 40) begin
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      if (dmem_req_o) begin
        if (req_seen >= gnt_dly) begin
          dmem_gnt_i = 1'b1;
          if (!we) rv_at = n + 1 + rv_dly;
        end
        req_seen++;
      end
      if (n == rv_at) dmem_rvalid_i = 1'b1;
      @(negedge clk);
      if (stall_o) stalls++;
      else done = 1'b1;
      tick();
      if (done) idle_inputs();
      n++;
    end
    if (!done) begin
      chk_cnt++;
      $display("FAIL %s_timeout: still stalled after %0d cycles, required %0d", name, n, exp_lat);
      idle_inputs();
    end else begin
      check({name, "_latency"}, 69'(n), 69'(exp_lat));
      check({name, "_stalls"}, 69'(stalls), 69'(exp_stalls));
    end
  endtask

  task automatic mis_op(input string name, input logic we, input data_size_e size,
                        input logic [31:0] a, input logic [4:0] rd);
    mem_re_i = ~we; mem_we_i = we; mem_size_i = size; alu_result_i = a;
    rs2_i = 32'hFFFF_FFFF; sel_rd_i = rd;
    @(negedge clk);
    check({name, "_stall"}, 69'(stall_o), 69'(0));
    check({name, "_no_req"}, 69'(dmem_req_o), 69'(0));
    tick();
    idle_inputs();
    @(negedge clk);
    check({name, "_pulse"}, 69'(misaligned_o), 69'(1));
    check({name, "_rd_zero"}, 69'(sel_rd_o), 69'(0));
    check({name, "_state"}, 69'(state_o), 69'(IDLE));
    tick();
    @(negedge clk);
    check({name, "_pulse_end"}, 69'(misaligned_o), 69'(0));
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    dmem_rdata_i = '0;
    rst = 1'b1;
    // Aligned access on the inputs during reset must not stall.
    mem_re_i = 1'b1; mem_size_i = DATA_WORD; alu_result_i = 32'h100; sel_rd_i = 5'd3;
    #12;
    check("rst_stall", 69'(stall_o), 69'(0));
    check("rst_req", 69'(dmem_req_o), 69'(0));
    check("rst_state", 69'(state_o), 69'(IDLE));
    check("rst_sel_rd", 69'(sel_rd_o), 69'(0));
    check("rst_wb", 69'(wb_data_o), 69'(0));
    check("rst_mis", 69'(misaligned_o), 69'(0));
    check("rst_fields", {dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o}, 69'(0));
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();

    // Reset while waiting for read data; late rvalid must be ignored.
    req_q.push_back({1'b0, 32'h0000_2000, 4'b1100, 32'h0});
    mem_re_i = 1'b1; mem_size_i = DATA_HALF; alu_result_i = 32'h2002; sel_rd_i = 5'd5;
    tick();                 // now in REQ
    dmem_gnt_i = 1'b1;
    tick();                 // now in WAIT
    dmem_gnt_i = 1'b0;
    @(negedge clk);
    check("wait_state", 69'(state_o), 69'(WAIT));
    check("wait_stall", 69'(stall_o), 69'(1));
    #1 rst = 1'b1;
    #1;
    check("async_rst_state", 69'(state_o), 69'(IDLE));
    check("async_rst_stall", 69'(stall_o), 69'(0));
    check("async_rst_req", 69'(dmem_req_o), 69'(0));
    idle_inputs();
    tick();
    rst = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h8001_0000;
    @(negedge clk);
    check("late_rvalid_stall", 69'(stall_o), 69'(0));
    tick();
    dmem_rvalid_i = 1'b0;
    @(negedge clk);
    check("late_rvalid_wb", 69'(wb_data_o), 69'(0));
    check("late_rvalid_rd", 69'(sel_rd_o), 69'(0));
    check("late_rvalid_state", 69'(state_o), 69'(IDLE));
    tick();

    // Directed loads/stores: name, we, size, uns, a, rs2, rd, gnt_dly, rv_dly,
    // rdata, exp_addr, exp_be, exp_wdata, exp_wb, exp_lat, exp_stalls
    mem_op("st_byte", 1'b1, DATA_BYTE, 1'b0, 32'h1003, 32'h55, 5'd0, 0, 0, 32'h0,
           32'h1000, 4'b1000, 32'h5555_5555, 32'h0, 2, 1);
    mem_op("st_half", 1'b1, DATA_HALF, 1'b0, 32'h1002, 32'hABCD_1234, 5'd0, 0, 0, 32'h0,
           32'h1000, 4'b1100, 32'h1234_1234, 32'h0, 2, 1);
    mem_op("st_word_gnt1", 1'b1, DATA_WORD, 1'b0, 32'h1008, 32'hDEAD_BEEF, 5'd0, 1, 0, 32'h0,
           32'h1008, 4'b1111, 32'hDEAD_BEEF, 32'h0, 3, 2);
    mem_op("ld_half_s", 1'b0, DATA_HALF, 1'b0, 32'h2002, 32'h0, 5'd5, 0, 0, 32'h8001_0000,
           32'h2000, 4'b1100, 32'h0, 32'hFFFF_8001, 3, 2);
    mem_op("ld_half_u_dly", 1'b0, DATA_HALF, 1'b1, 32'h2002, 32'h0, 5'd5, 2, 1, 32'h8001_0000,
           32'h2000, 4'b1100, 32'h0, 32'h0000_8001, 6, 5);
    mem_op("ld_byte_s", 1'b0, DATA_BYTE, 1'b0, 32'h4001, 32'h0, 5'd10, 0, 0, 32'h1234_8056,
           32'h4000, 4'b0010, 32'h0, 32'hFFFF_FF80, 3, 2);
    mem_op("ld_byte_u", 1'b0, DATA_BYTE, 1'b1, 32'h4003, 32'h0, 5'd11, 0, 0, 32'hA500_0000,
           32'h4000, 4'b1000, 32'h0, 32'h0000_00A5, 3, 2);
    mem_op("ld_word", 1'b0, DATA_WORD, 1'b0, 32'h4004, 32'h0, 5'd31, 0, 0, 32'hCAFE_F00D,
           32'h4004, 4'b1111, 32'h0, 32'hCAFE_F00D, 3, 2);
    mem_op("ld_half_lo_rv2", 1'b0, DATA_HALF, 1'b0, 32'h4000, 32'h0, 5'd12, 0, 2, 32'h1234_FEDC,
           32'h4000, 4'b0011, 32'h0, 32'hFFFF_FEDC, 5, 4);

    // Misaligned accesses.
    mis_op("mis_ld_word", 1'b0, DATA_WORD, 32'h3001, 5'd9);
    mis_op("mis_st_half", 1'b1, DATA_HALF, 32'h3003, 5'd4);

    // Pass-through ALU result.
    wb_q.push_back({5'd7, 32'h1234});
    alu_result_i = 32'h1234; sel_rd_i = 5'd7;
    @(negedge clk);
    check("alu_no_stall", 69'(stall_o), 69'(0));
    tick();
    idle_inputs();
    @(negedge clk);
    check("alu_wb", 69'(wb_data_o), 69'(32'h1234));
    check("alu_rd", 69'(sel_rd_o), 69'(7));
    tick();

    // Stray rvalid in IDLE must not produce a writeback.
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    tick();
    dmem_rvalid_i = 1'b0;
    @(negedge clk);
    check("idle_rvalid_state", 69'(state_o), 69'(IDLE));
    tick();
    tick();

    check("req_queue_drained", 69'(req_q.size()), 69'(0));
    check("wb_queue_drained", 69'(wb_q.size()), 69'(0));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1, "timeout");
  end

endmodule
